// File: rtl/cpu_mem_pkg.sv
// Shared encodings, payload type and lane helpers for the memory-access stage.
package cpu_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned CNT_W  = 8;

    // memSize encodings; 2'd3 falls through to word handling
    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
    localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Registered command presented on the data-memory bus
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    // Natural alignment check for the access size
    function automatic logic is_misaligned(input logic [SIZE_W-1:0] size,
                                           input logic [1:0]        lane);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lane[0];
            default:   return lane != 2'b00;
        endcase
    endfunction

    // Lane enables for an aligned access
    function automatic logic [BE_W-1:0] byte_enable(input logic [SIZE_W-1:0] size,
                                                    input logic [1:0]        lane);
        case (size)
            SIZE_BYTE: return BE_BYTE0 << lane;
            SIZE_HALF: return lane[1] ? BE_HALF_HI : BE_HALF_LO;
            default:   return BE_WORD;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane it could occupy
    function automatic logic [DATA_W-1:0] store_lanes(input logic [SIZE_W-1:0] size,
                                                      input logic [DATA_W-1:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Handshaked data-memory bus between the memory stage and the memory system.
interface mem_stage_if;
    import cpu_mem_pkg::*;

    logic              busReq;
    logic              busWe;
    logic [ADDR_W-1:0] busAddr;
    logic [BE_W-1:0]   busByteEn;
    logic [DATA_W-1:0] busWData;
    logic              busAck;
    logic [DATA_W-1:0] busRData;

    modport master (
        output busReq, busWe, busAddr, busByteEn, busWData,
        input  busAck, busRData
    );

    modport slave (
        input  busReq, busWe, busAddr, busByteEn, busWData,
        output busAck, busRData
    );

endinterface

// File: rtl/load_align.sv
// Selects the addressed lane of a read word and sign/zero extends it.
module load_align
    import cpu_mem_pkg::*;
(
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_lane,
    input  logic [SIZE_W-1:0] i_size,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select for byte and halfword views of the read word
    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extension to full register width
    always_comb begin
        case (i_size)
            SIZE_BYTE: o_data_c = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SIZE_HALF: o_data_c = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default:   o_data_c = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one bus transaction per aligned load/store,
// stalls the front of the pipeline until it completes, and extends load data.
module mem_stage
    import cpu_mem_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [SIZE_W-1:0] memSize,
    input  logic              memUnsigned,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] writeData,
    mem_stage_if.master       bus,
    output logic [DATA_W-1:0] memOut,
    output logic              regWriteOut,
    output logic              stall,
    output logic              misaligned,
    output logic              busError
);

    // Counter value on which a still-unacknowledged request is abandoned
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUS_TIMEOUT - 1);
    localparam bit               TO_EN   = (BUS_TIMEOUT != 0);

    state_e            r_state;
    state_e            w_next_state;
    bus_cmd_t          r_cmd;
    bus_cmd_t          w_cmd;
    logic              r_busReq;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fault;
    logic [1:0]        r_lane;
    logic [SIZE_W-1:0] r_size;
    logic              r_uns;
    logic [DATA_W-1:0] r_memOut;
    logic [DATA_W-1:0] w_load;
    logic              w_access;
    logic              w_mis;
    logic              w_to_hit;

    // Decode of the instruction held in ex_mem
    always_comb begin
        w_access = memRead | memWrite;
        w_mis    = is_misaligned(memSize, ALUOut[1:0]);
        w_to_hit = TO_EN && (r_cnt == TO_LAST);
        w_cmd    = '{addr:  {ALUOut[ADDR_W-1:2], 2'b00},
                     we:    memWrite,
                     be:    byte_enable(memSize, ALUOut[1:0]),
                     wdata: store_lanes(memSize, writeData)};
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and pipeline-facing control
    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        misaligned   = 1'b0;
        regWriteOut  = 1'b0;
        busError     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access && w_mis) begin
                    misaligned = 1'b1;
                end else if (w_access) begin
                    stall        = 1'b1;
                    w_next_state = ST_BUS;
                end else begin
                    regWriteOut = regWrite;
                end
            end
            ST_BUS: begin
                stall = 1'b1;
                if (bus.busAck || w_to_hit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                regWriteOut  = regWrite & ~r_fault;
                busError     = r_fault;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (!reset) begin
            w_next_state = ST_IDLE;
            stall        = 1'b0;
            misaligned   = 1'b0;
            regWriteOut  = 1'b0;
            busError     = 1'b0;
        end
    end

    // Bus command, wait counter, fault flag and load result registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_busReq <= 1'b0;
            r_cmd    <= '0;
            r_cnt    <= '0;
            r_fault  <= 1'b0;
            r_lane   <= 2'b00;
            r_size   <= SIZE_BYTE;
            r_uns    <= 1'b0;
            r_memOut <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access && !w_mis) begin
                        r_busReq <= 1'b1;
                        r_cmd    <= w_cmd;
                        r_cnt    <= '0;
                        r_fault  <= 1'b0;
                        r_lane   <= ALUOut[1:0];
                        r_size   <= memSize;
                        r_uns    <= memUnsigned;
                    end
                end
                ST_BUS: begin
                    if (bus.busAck) begin
                        r_busReq <= 1'b0;
                        if (!r_cmd.we) begin
                            r_memOut <= w_load;
                        end
                    end else if (w_to_hit) begin
                        r_busReq <= 1'b0;
                        r_memOut <= '0;
                        r_fault  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: r_fault <= 1'b0;
                default: r_fault <= 1'b0;
            endcase
        end
    end

    load_align u_load_align (
        .i_rdata    (bus.busRData),
        .i_lane     (r_lane),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data_c   (w_load)
    );

    // Bus outputs come straight from the held command
    assign bus.busReq    = r_busReq;
    assign bus.busWe     = r_cmd.we;
    assign bus.busAddr   = r_cmd.addr;
    assign bus.busByteEn = r_cmd.be;
    assign bus.busWData  = r_cmd.wdata;
    assign memOut        = r_memOut;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, randomized transactions
// against an arithmetic reference model, reset abort and timeout sequences.
module tb_mem_stage;
    import cpu_mem_pkg::*;

    logic        clock;
    logic        reset;
    logic        memRead, memWrite, memUnsigned, regWrite;
    logic [1:0]  memSize;
    logic [31:0] ALUOut, writeData;
    logic [31:0] memOut, memOut4;
    logic        regWriteOut, stall, misaligned, busError;
    logic        regWriteOut4, stall4, misaligned4, busError4;

    mem_stage_if bus_if ();
    mem_stage_if bus4_if ();

    mem_stage dut (
        .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .memSize(memSize), .memUnsigned(memUnsigned), .regWrite(regWrite),
        .ALUOut(ALUOut), .writeData(writeData), .bus(bus_if), .memOut(memOut),
        .regWriteOut(regWriteOut), .stall(stall), .misaligned(misaligned),
        .busError(busError)
    );

    mem_stage #(.BUS_TIMEOUT(4)) dut4 (
        .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .memSize(memSize), .memUnsigned(memUnsigned), .regWrite(regWrite),
        .ALUOut(ALUOut), .writeData(writeData), .bus(bus4_if), .memOut(memOut4),
        .regWriteOut(regWriteOut4), .stall(stall4), .misaligned(misaligned4),
        .busError(busError4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd, wr;
        logic [1:0]  size;
        logic        uns, regw;
        logic [31:0] addr, wdata, rdata;
        int          delay;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd, mem;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        memRead = 0; memWrite = 0; memSize = 0; memUnsigned = 0;
        regWrite = 0; ALUOut = 0; writeData = 0;
    endtask

    // Reference model: plain arithmetic over byte counts and offsets
    function automatic int m_nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
        return (a % m_nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int n = m_nbytes(sz);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
        int n = m_nbytes(sz);
        longint unsigned v = longint'(d) % (longint'(1) << (8 * n));
        longint unsigned res = 0;
        for (int k = 0; k < 4 / n; k++) res = res + (v << (8 * n * k));
        return 32'(res);
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
        int n = m_nbytes(sz);
        longint span = longint'(1) << (8 * n);
        longint v = (longint'(rd) >> (8 * (a % 4))) % span;
        if (!uns && n < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // One instruction through the stage, from IDLE back to IDLE
    task automatic run_vec(input vec_t v, input int tag);
        int stalls = 0;
        string t = $sformatf("v%0d", tag);
        memRead = v.rd; memWrite = v.wr; memSize = v.size; memUnsigned = v.uns;
        regWrite = v.regw; ALUOut = v.addr; writeData = v.wdata;
        bus_if.busAck = 0; bus_if.busRData = $urandom;
        #1;
        if (!(v.rd || v.wr)) begin
            chk({t, "_noacc_stall"}, stall, 0);
            chk({t, "_noacc_regwr"}, regWriteOut, v.regw);
            chk({t, "_noacc_mis"}, misaligned, 0);
            step();
            chk({t, "_noacc_req"}, bus_if.busReq, 0);
            chk({t, "_noacc_mem"}, memOut, v.mem);
        end else if (v.mis) begin
            chk({t, "_mis_flag"}, misaligned, 1);
            chk({t, "_mis_stall"}, stall, 0);
            chk({t, "_mis_regwr"}, regWriteOut, 0);
            step();
            idle_inputs();
            #1;
            chk({t, "_mis_req"}, bus_if.busReq, 0);
            chk({t, "_mis_mem"}, memOut, v.mem);
            chk({t, "_mis_pulse"}, misaligned, 0);
        end else begin
            chk({t, "_idle_stall"}, stall, 1);
            chk({t, "_idle_mis"}, misaligned, 0);
            chk({t, "_idle_regwr"}, regWriteOut, 0);
            stalls += int'(stall);
            step();
            for (int i = 0; i <= v.delay; i++) begin
                chk({t, "_bus_req"}, bus_if.busReq, 1);
                chk({t, "_bus_we"}, bus_if.busWe, v.wr);
                chk({t, "_bus_addr"}, bus_if.busAddr, {v.addr[31:2], 2'b00});
                chk({t, "_bus_be"}, bus_if.busByteEn, v.be);
                chk({t, "_bus_wdata"}, bus_if.busWData, v.wd);
                stalls += int'(stall);
                bus_if.busAck = (i == v.delay);
                bus_if.busRData = bus_if.busAck ? v.rdata : $urandom;
                step();
            end
            bus_if.busAck = 0; bus_if.busRData = $urandom;
            chk({t, "_done_stall"}, stall, 0);
            chk({t, "_done_regwr"}, regWriteOut, v.regw);
            chk({t, "_done_err"}, busError, 0);
            chk({t, "_done_req"}, bus_if.busReq, 0);
            chk({t, "_done_mem"}, memOut, v.mem);
            chk({t, "_stall_cycles"}, stalls, v.delay + 2);
        end
        idle_inputs();
        if (!(v.rd || v.wr) || v.mis) begin
            #1;
        end else begin
            step();
            chk({t, "_back_idle"}, stall, 0);
        end
    endtask

    task automatic pulse_reset();
        reset = 0;
        step(); step();
        reset = 1;
        #1;
    endtask

    vec_t tbl[14];
    vec_t v;
    logic [31:0] m_mem;
    int cnt;

    initial begin
        // rd wr size uns regw addr wdata rdata delay | mis be wd mem
        tbl[0]  = '{1'b1,1'b0,2'd2,1'b0,1'b1,32'h100,32'h0,32'hDEADBEEF,0, 1'b0,4'hF,32'h0,32'hDEADBEEF};
        tbl[1]  = '{1'b1,1'b0,2'd0,1'b0,1'b1,32'h103,32'h0,32'h80112233,0, 1'b0,4'h8,32'h0,32'hFFFFFF80};
        tbl[2]  = '{1'b1,1'b0,2'd0,1'b1,1'b1,32'h103,32'h0,32'h80112233,1, 1'b0,4'h8,32'h0,32'h00000080};
        tbl[3]  = '{1'b0,1'b1,2'd1,1'b0,1'b0,32'h202,32'h0000ABCD,32'h12345678,3, 1'b0,4'hC,32'hABCDABCD,32'h00000080};
        tbl[4]  = '{1'b1,1'b0,2'd2,1'b0,1'b1,32'h101,32'h0,32'h0,0, 1'b1,4'h0,32'h0,32'h00000080};
        tbl[5]  = '{1'b1,1'b0,2'd1,1'b0,1'b1,32'h102,32'h0,32'h80011234,2, 1'b0,4'hC,32'h0,32'hFFFF8001};
        tbl[6]  = '{1'b1,1'b0,2'd1,1'b1,1'b0,32'h100,32'h0,32'h1234F00D,0, 1'b0,4'h3,32'h0,32'h0000F00D};
        tbl[7]  = '{1'b0,1'b1,2'd0,1'b0,1'b0,32'h101,32'h123456A5,32'h0,1, 1'b0,4'h2,32'hA5A5A5A5,32'h0000F00D};
        tbl[8]  = '{1'b0,1'b1,2'd1,1'b0,1'b0,32'h203,32'h1111,32'h0,0, 1'b1,4'h0,32'h0,32'h0000F00D};
        tbl[9]  = '{1'b1,1'b1,2'd0,1'b0,1'b1,32'h102,32'h0000005A,32'hFFFFFFFF,0, 1'b0,4'h4,32'h5A5A5A5A,32'h0000F00D};
        tbl[10] = '{1'b1,1'b0,2'd3,1'b0,1'b1,32'h104,32'h0,32'h0BADF00D,4, 1'b0,4'hF,32'h0,32'h0BADF00D};
        tbl[11] = '{1'b1,1'b0,2'd2,1'b1,1'b1,32'h106,32'h0,32'h0,0, 1'b1,4'h0,32'h0,32'h0BADF00D};
        tbl[12] = '{1'b0,1'b0,2'd2,1'b0,1'b1,32'h300,32'h0,32'h0,0, 1'b0,4'h0,32'h0,32'h0BADF00D};
        tbl[13] = '{1'b1,1'b0,2'd0,1'b0,1'b1,32'h100,32'h0,32'h0000007F,0, 1'b0,4'h1,32'h0,32'h0000007F};

        idle_inputs();
        bus_if.busAck = 0; bus_if.busRData = 0;
        bus4_if.busAck = 0; bus4_if.busRData = 0;
        reset = 0;
        step(); step(); step();
        chk("rst_req", bus_if.busReq, 0);
        chk("rst_we", bus_if.busWe, 0);
        chk("rst_addr", bus_if.busAddr, 0);
        chk("rst_be", bus_if.busByteEn, 0);
        chk("rst_wdata", bus_if.busWData, 0);
        chk("rst_mem", memOut, 0);
        chk("rst_mis", misaligned, 0);
        chk("rst_err", busError, 0);
        chk("rst_stall", stall, 0);
        reset = 1;
        #1;

        for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

        // Randomized transactions against the model
        m_mem = 32'h0000007F;
        for (int i = 0; i < 40; i++) begin
            int kind = int'($urandom_range(0, 7));
            v.rd = (kind != 0) && (kind <= 5 || kind == 7);
            v.wr = (kind == 6 || kind == 7);
            v.size = 2'($urandom_range(0, 3));
            v.uns = 1'($urandom_range(0, 1));
            v.regw = 1'($urandom_range(0, 1));
            v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
            v.delay = int'($urandom_range(0, 5));
            v.mis = (v.rd || v.wr) && m_mis(v.size, v.addr);
            v.be = m_be(v.size, v.addr);
            v.wd = m_wd(v.size, v.wdata);
            if (v.rd && !v.wr && !v.mis) m_mem = m_load(v.size, v.uns, v.addr, v.rdata);
            v.mem = m_mem;
            run_vec(v, 100 + i);
        end

        // Reset in the second BUS cycle aborts the transaction
        run_vec(tbl[0], 200);
        memRead = 1; memSize = 2; regWrite = 1; ALUOut = 32'h100;
        #1;
        step();
        step();
        chk("rstbus_req_before", bus_if.busReq, 1);
        reset = 0;
        bus_if.busAck = 1; bus_if.busRData = 32'h55555555;
        step();
        chk("rstbus_req", bus_if.busReq, 0);
        chk("rstbus_mem", memOut, 0);
        chk("rstbus_stall", stall, 0);
        reset = 1;
        idle_inputs();
        #1;
        chk("rstbus_idle_stall", stall, 0);
        step();
        chk("late_ack_mem", memOut, 0);
        chk("late_ack_req", bus_if.busReq, 0);
        bus_if.busAck = 0;
        run_vec(tbl[0], 201);

        // Timeout with BUS_TIMEOUT=4, after a successful load sets memOut
        pulse_reset();
        memRead = 1; memSize = 2; regWrite = 1; ALUOut = 32'h100;
        #1;
        chk("to4_idle_stall", stall4, 1);
        step();
        bus4_if.busAck = 1; bus4_if.busRData = 32'h11223344;
        step();
        bus4_if.busAck = 0;
        chk("to4_pre_mem", memOut4, 32'h11223344);
        chk("to4_pre_regwr", regWriteOut4, 1);
        step();
        chk("to4_relaunch_stall", stall4, 1);
        step();
        cnt = 0;
        while (bus4_if.busReq && cnt < 20) begin
            cnt++;
            step();
        end
        chk("to4_req_cycles", cnt, 4);
        chk("to4_err", busError4, 1);
        chk("to4_mem", memOut4, 0);
        chk("to4_regwr", regWriteOut4, 0);
        chk("to4_stall", stall4, 0);
        idle_inputs();
        step();
        chk("to4_err_pulse", busError4, 0);

        // Default timeout at its maximum of 255 wait cycles
        pulse_reset();
        memRead = 1; memSize = 2; regWrite = 1; ALUOut = 32'h200;
        #1;
        step();
        cnt = 0;
        while (bus_if.busReq && cnt < 300) begin
            cnt++;
            step();
        end
        chk("to255_req_cycles", cnt, 255);
        chk("to255_err", busError, 1);
        chk("to255_mem", memOut, 0);
        chk("to255_regwr", regWriteOut, 0);
        idle_inputs();
        step();
        chk("to255_err_pulse", busError, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline, between ex_mem and mem_wb.
- Turns load/store controls and ALU address into a handshaked data-memory bus transaction: byte-lane alignment, load extension, pipeline stall while the bus is busy.
- Produces memOut and the gated regWrite consumed by mem_wb.

Parameters:
- BUS_TIMEOUT, 255, cycles waited in BUS for busAck before abort; 0 disables timeout; max 255.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-low; block held in reset while reset==0.
- memRead  in  1  load request from ex_mem.
- memWrite  in  1  store request from ex_mem.
- memSize  in  2  0=byte, 1=half, 2=word; 3 treated as word.
- memUnsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- regWrite  in  1  regWrite from ex_mem.
- ALUOut  in  32  effective address.
- writeData  in  32  store data, right-aligned.
- busReq  out  1  bus request.
- busWe  out  1  1=write.
- busAddr  out  32  word address, bits[1:0]=0.
- busByteEn  out  4  lane enables.
- busWData  out  32  lane-replicated store data.
- busAck  in  1  transaction complete.
- busRData  in  32  read word, valid with busAck.
- memOut  out  32  extended load result to mem_wb.
- regWriteOut  out  1  regWrite gated by faults.
- stall  out  1  freeze pc/if_id/id_ex/ex_mem.
- misaligned  out  1  one-cycle fault pulse.
- busError  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (reset==0 at edge): state=IDLE, counter=0, busReq=0, busWe=0, busAddr=0, busByteEn=0, busWData=0, memOut=0, misaligned=0, busError=0. Applies mid-transaction: busReq drops at that edge, no capture.
- access = memRead|memWrite. Both high: store only.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0. No bus transaction, stall=0; misaligned=1 that cycle (combinational); regWriteOut=0; memOut unchanged.
- States IDLE, BUS, DONE.
- IDLE:
  - aligned access: stall=1; at edge register busAddr={addr[31:2],2'b00}, busWe, busByteEn, busWData; busReq=1; clear counter; go BUS.
  - otherwise: stall=0; regWriteOut=regWrite.
- BUS:
  - stall=1; all bus outputs held stable.
  - busAck=1 at edge: load captures extended busRData into memOut; busReq=0; go DONE. Ack in the first BUS cycle is legal.
  - no ack: counter++.
  - Timeout: counter==BUS_TIMEOUT-1 without ack (BUS_TIMEOUT!=0): busReq=0, memOut=0, go DONE with fault flag set.
- DONE:
  - stall=0; regWriteOut=regWrite & ~fault; busError=fault for this cycle.
  - Always returns to IDLE. The held ex_mem instruction advances at this edge and is never re-issued.
- Minimum latency: 3 cycles (IDLE, BUS, DONE), 2 of them stalled.
- Byte enables:
  - byte: 1<<addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
  - busWData: byte replicated ×4, half ×2, word as-is.
- Load extract: lane selected by addr[1:0]; sign or zero extend per memUnsigned.
- memOut holds its last value between loads.

Decomposition:
- Package cpu_mem_pkg: memSize encodings (SIZE_BYTE/HALF/WORD), state encoding (ST_IDLE/BUS/DONE), byte-enable constants.
- Sub-module load_align: combinational lane select plus extension from busRData, addr[1:0], memSize, memUnsigned. Reused later for forwarding checks.

Test Plan:
- lw addr 0x100, busAck on 1st BUS cycle, busRData=0xDEADBEEF -> busAddr=0x100, busByteEn=1111, stall high 2 cycles, DONE memOut=0xDEADBEEF, regWriteOut=1.
- lb addr 0x103 signed, busRData=0x80112233 -> busByteEn=1000, memOut=0xFFFFFF80. lbu same -> memOut=0x00000080.
- sh addr 0x202, writeData=0x0000ABCD, ack after 4 cycles -> busWe=1, busByteEn=1100, busWData=0xABCDABCD, stall held 5 cycles, outputs stable throughout.
- lw addr 0x101 -> misaligned=1 same cycle, busReq never 1, stall=0, regWriteOut=0.
- BUS_TIMEOUT=4, lw with no ack -> busReq high 4 cycles then 0, busError=1 in DONE, memOut=0, regWriteOut=0.
- Reset (reset=0) in 2nd BUS cycle -> next edge busReq=0, state IDLE, memOut=0. Late busAck after release is ignored.
